cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common-data-bus arbiter for the out-of-order core. Functional units (ALU, multiplier, load unit, branch unit) each deposit completed results into a private one-entry holding slot. The arbiter picks one full slot per cycle round-robin and drives the winner onto a registered CDB broadcast. Reservation stations, the ROB and the register-alias table consume that broadcast. It sits inside the core between the execute stage and writeback/wakeup, and it is the only writer of the CDB.

## Interface
Parameters:
- NUM_FU, 4, number of requesting functional units (2..8)
- TAG_W, 6, ROB/physical tag width
- DATA_W, 32, result width

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- fu_valid  input  NUM_FU  FU i presents a result
- fu_tag  input  NUM_FU x TAG_W  per-FU result tag
- fu_data  input  NUM_FU x DATA_W  per-FU result value
- fu_ready  output  NUM_FU  slot i accepts this cycle; transfer when fu_valid[i] & fu_ready[i]
- cdb_valid  output  1  broadcast valid (registered)
- cdb_tag  output  TAG_W  broadcast tag (registered)
- cdb_data  output  DATA_W  broadcast value (registered)
- cdb_src  output  clog2(NUM_FU)  index of the winning FU (registered)
- flush  input  1  present only with CDB_FLUSH_EN

## Operation
- Per FU: holding slot {full, tag, data}. The CDB has no backpressure; consumers always accept.
- Arbitration, combinational each cycle: candidate set = full slots. Winner = first full slot scanning from rr_ptr upward, wrapping modulo NUM_FU.
- Winner update on the edge: cdb_* <= slot contents, cdb_valid <= 1, cdb_src <= winner, rr_ptr <= (winner+1) mod NUM_FU.
- No candidates: cdb_valid <= 0. cdb_tag/cdb_data/cdb_src hold their previous values. rr_ptr is unchanged.
- fu_ready[i] = ~full[i] | grant[i]. This allows same-cycle drain and refill, so sustained one result per cycle per FU is possible when that FU wins.
- Slot update: an accepted transfer sets full and loads tag/data. A grant without a refill clears full. A simultaneous grant and refill keeps full = 1 with the new contents.
- Requirement on the FU side: once fu_valid is high it stays high, with tag/data stable, until accepted. Violation is checked by a bench assertion, not by the RTL.

## Timing
- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, all full=0, rr_ptr=0, fu_ready=all 1s on the cycle after reset deasserts.
- While reset is high, fu_ready=0 and any accept is ignored.
- Minimum latency: accept at edge E0, broadcast visible after E1 (2 edges from fu_valid to cdb_valid).
- Throughput: one broadcast per cycle whenever any slot is full.
- Worst-case wait of a full slot: NUM_FU-1 grants to others.
- Reset asserted mid-operation: all slot contents are discarded, with no broadcast on the following cycle.
- rr_ptr wraps NUM_FU-1 -> 0. For non-power-of-two NUM_FU the pointer never takes out-of-range values.

## Configuration
- CDB_FLUSH_EN defined: the flush port exists.
  - Flush high at an edge: all full <= 0, cdb_valid <= 0, and no grant or rr_ptr update.
  - fu_ready is forced to 0 while flush is high, so nothing is accepted that cycle.
  - Next cycle behaves as post-reset, except that rr_ptr is preserved.
- CDB_FLUSH_EN undefined: there is no flush port and no flush logic. Recovery is by reset only.

## Structure
- Shared package cdb_pkg holds:
  - cdb_pkt_t struct {tag, data}
  - default NUM_FU/TAG_W/DATA_W constants
  - FU index localparams (FU_ALU=0, FU_MUL=1, FU_LD=2, FU_BR=3)
- One sub-module, cdb_rr_pick: purely combinational. Inputs are the req vector and ptr; outputs are a one-hot grant, a binary index and any_req. It is reusable by the issue-select logic.
- The top level holds the slots, pointer and output register.

## Test plan
- Reset: hold reset 2 cycles with fu_valid=4'b1111. Required: no accepts and cdb_valid=0; after release, fu_ready=4'b1111 and first broadcast 2 edges after release.
- Single FU: FU2 presents tag 0x05/data 0xDEADBEEF once. Required: cdb_valid high exactly one cycle with tag 0x05, data 0xDEADBEEF, cdb_src=2.
- Round-robin fairness: all four FUs valid continuously with distinct tags. Required: cdb_src sequence 0,1,2,3,0,…, cdb_valid high every cycle, no tag lost or duplicated.
- Drain+refill: FU1 streams tags 0x10..0x17 back-to-back while alone. Required: eight consecutive broadcasts in order, fu_ready[1] never low.
- Pointer wrap / skip: rr_ptr=3 and only FU0 and FU2 full. Required: grant FU0, then FU2, and rr_ptr=3 afterward.
- Flush (CDB_FLUSH_EN): with slots 0 and 3 full, pulse flush. Required: next cycle cdb_valid=0, both slots empty, rr_ptr unchanged; a later request broadcasts normally.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter and its clients.
package cdb_pkg;

   localparam int CDB_NUM_FU = 4;
   localparam int CDB_TAG_W  = 6;
   localparam int CDB_DATA_W = 32;

   localparam int FU_ALU = 0;
   localparam int FU_MUL = 1;
   localparam int FU_LD  = 2;
   localparam int FU_BR  = 3;

   typedef struct packed {
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_pkt_t;

   // Index width that stays at least one bit for degenerate counts.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result handshake plus registered CDB broadcast; slave = arbiter, master = FU/consumer side.
interface cdb_arbiter_if import cdb_pkg::*; #(
   parameter int NUM_FU = CDB_NUM_FU,
   parameter int TAG_W  = CDB_TAG_W,
   parameter int DATA_W = CDB_DATA_W
) ();
   localparam int SRC_W = idx_w(NUM_FU);

   logic [NUM_FU-1:0]             fu_valid;
   logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag;
   logic [NUM_FU-1:0][DATA_W-1:0] fu_data;
   logic [NUM_FU-1:0]             fu_ready;
   logic                          cdb_valid;
   logic [TAG_W-1:0]              cdb_tag;
   logic [DATA_W-1:0]             cdb_data;
   logic [SRC_W-1:0]              cdb_src;

   modport slave (
      input  fu_valid, fu_tag, fu_data,
      output fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );

   modport master (
      output fu_valid, fu_tag, fu_data,
      input  fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );

endinterface

// File: rtl/cdb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping modulo N.
module cdb_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_req_o
);

   always_comb begin
      int   cand;
      logic found;
      grant_o   = '0;
      idx_o     = '0;
      found     = 1'b0;
      cand      = 0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= N) cand = cand - N;
         if (!found && req_i[IDX_W'(cand)]) begin
            found                   = 1'b1;
            grant_o[IDX_W'(cand)]   = 1'b1;
            idx_o                   = IDX_W'(cand);
         end
      end
      any_req_o = found;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-FU one-entry slots, round-robin pick, registered broadcast.
// Optional flush port enabled by defining CDB_FLUSH_EN.
module cdb_arbiter import cdb_pkg::*; #(
   parameter int NUM_FU = CDB_NUM_FU,
   parameter int TAG_W  = CDB_TAG_W,
   parameter int DATA_W = CDB_DATA_W
) (
   input  logic clk,
   input  logic reset,
`ifdef CDB_FLUSH_EN
   input  logic flush,
`endif
   cdb_arbiter_if.slave bus
);
   localparam int SRC_W = idx_w(NUM_FU);

   logic [NUM_FU-1:0]             full_q, full_d;
   logic [NUM_FU-1:0][TAG_W-1:0]  tag_q, tag_d;
   logic [NUM_FU-1:0][DATA_W-1:0] data_q, data_d;
   logic [SRC_W-1:0]              rr_ptr_q, rr_ptr_d;
   logic                          cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]              cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0]             cdb_data_q, cdb_data_d;
   logic [SRC_W-1:0]              cdb_src_q, cdb_src_d;

   logic [NUM_FU-1:0] pick_grant, grant, ready, accept;
   logic [SRC_W-1:0]  pick_idx;
   logic              pick_any, win;
   logic              flush_act;

`ifdef CDB_FLUSH_EN
   assign flush_act = flush;
`else
   assign flush_act = 1'b0;
`endif

   cdb_rr_pick #(.N(NUM_FU), .IDX_W(SRC_W)) u_pick (
      .req_i     (full_q),
      .ptr_i     (rr_ptr_q),
      .grant_o   (pick_grant),
      .idx_o     (pick_idx),
      .any_req_o (pick_any)
   );

   assign win    = pick_any & ~flush_act;
   assign grant  = pick_grant & {NUM_FU{~flush_act}};
   // A granted slot may be refilled in the same cycle it drains.
   assign ready  = (reset | flush_act) ? '0 : (~full_q | grant);
   assign accept = bus.fu_valid & ready;

   always_comb begin
      full_d      = full_q;
      tag_d       = tag_q;
      data_d      = data_q;
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      cdb_src_d   = cdb_src_q;
      if (flush_act) begin
         full_d = '0;
      end else begin
         if (win) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = tag_q[pick_idx];
            cdb_data_d  = data_q[pick_idx];
            cdb_src_d   = pick_idx;
            rr_ptr_d    = (pick_idx == SRC_W'(NUM_FU - 1)) ? '0 : pick_idx + SRC_W'(1);
         end
         for (int i = 0; i < NUM_FU; i++) begin
            if (grant[i]) full_d[i] = 1'b0;
            if (accept[i]) begin
               full_d[i] = 1'b1;
               tag_d[i]  = bus.fu_tag[i];
               data_d[i] = bus.fu_data[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full_q      <= '0;
         tag_q       <= '0;
         data_q      <= '0;
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         cdb_src_q   <= '0;
      end else begin
         full_q      <= full_d;
         tag_q       <= tag_d;
         data_q      <= data_d;
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         cdb_src_q   <= cdb_src_d;
      end
   end

   assign bus.fu_ready  = ready;
   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_tag   = cdb_tag_q;
   assign bus.cdb_data  = cdb_data_q;
   assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed sequences, a vector table and random traffic vs a slot model.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int N  = 4;
   localparam int TW = 6;
   localparam int DW = 32;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   cdb_arbiter_if #(.NUM_FU(N), .TAG_W(TW), .DATA_W(DW)) bus ();

   cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
`ifdef CDB_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: one holding slot per FU, pointer, registered broadcast.
   bit              mfull [N];
   logic [TW-1:0]   mtag  [N];
   logic [DW-1:0]   mdata [N];
   int              mptr;
   logic            mcv;
   logic [TW-1:0]   mct;
   logic [DW-1:0]   mcd;
   int              mcs;

   logic [N-1:0]    acc;
   int              obs_src [$];
   logic [TW-1:0]   obs_tag [$];
   logic [DW-1:0]   obs_data[$];
   int              obs_cyc [$];

   // FU-side protocol: a stalled valid must persist with stable payload.
   logic [N-1:0]           hold_q = '0;
   logic [N-1:0][TW-1:0]   htag_q;
   logic [N-1:0][DW-1:0]   hdata_q;
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (hold_q[i]) begin
            assert (bus.fu_valid[i] && bus.fu_tag[i] == htag_q[i] && bus.fu_data[i] == hdata_q[i])
            else begin
               errors++;
               $display("FAIL fu_protocol fu%0d dropped or changed while stalled", i);
            end
         end
      end
      hold_q  <= bus.fu_valid & ~bus.fu_ready & {N{~reset}};
      htag_q  <= bus.fu_tag;
      hdata_q <= bus.fu_data;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mfull[i] = 1'b0;
         mtag[i]  = '0;
         mdata[i] = '0;
      end
      mptr = 0; mcv = 1'b0; mct = '0; mcd = '0; mcs = 0;
   endtask

   task automatic cycle();
      int           win;
      logic [N-1:0] rexp;
      logic [N-1:0] rdy;
      @(negedge clk);
      win = -1;
      if (!reset && !flush)
         for (int k = 0; k < N; k++)
            if (win < 0 && mfull[(mptr + k) % N]) win = (mptr + k) % N;
      for (int i = 0; i < N; i++) rexp[i] = !reset && !flush && (!mfull[i] || i == win);
      chk("fu_ready",  64'(bus.fu_ready),  64'(rexp));
      chk("cdb_valid", 64'(bus.cdb_valid), 64'(mcv));
      chk("cdb_tag",   64'(bus.cdb_tag),   64'(mct));
      chk("cdb_data",  64'(bus.cdb_data),  64'(mcd));
      chk("cdb_src",   64'(bus.cdb_src),   64'(mcs));
      if (bus.cdb_valid) begin
         obs_src.push_back(int'(bus.cdb_src));
         obs_tag.push_back(bus.cdb_tag);
         obs_data.push_back(bus.cdb_data);
         obs_cyc.push_back(cyc);
      end
      rdy = bus.fu_ready;
      if (reset) begin
         model_reset();
      end else if (flush) begin
         for (int i = 0; i < N; i++) mfull[i] = 1'b0;
         mcv = 1'b0;
      end else begin
         if (win >= 0) begin
            mcv = 1'b1; mct = mtag[win]; mcd = mdata[win]; mcs = win;
            mptr = (win + 1) % N;
            mfull[win] = 1'b0;
         end else begin
            mcv = 1'b0;
         end
         for (int i = 0; i < N; i++)
            if (bus.fu_valid[i] && rexp[i]) begin
               mfull[i] = 1'b1; mtag[i] = bus.fu_tag[i]; mdata[i] = bus.fu_data[i];
            end
      end
      acc = bus.fu_valid & rdy;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
      bus.fu_valid[i] = 1'b1;
      bus.fu_tag[i]   = t;
      bus.fu_data[i]  = d;
   endtask

   task automatic drop_acc();
      bus.fu_valid = bus.fu_valid & ~acc;
   endtask

   task automatic clear_obs();
      obs_src.delete(); obs_tag.delete(); obs_data.delete(); obs_cyc.delete();
   endtask

   typedef struct packed {
      logic [N-1:0]      mask;
      logic [2:0]        n;
      logic [0:3][1:0]   src;
      logic [1:0]        ptr_after;
   } vec_t;

   vec_t tbl [6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq [N];
      int ptr_save;
      tbl[0] = '{mask: 4'b0101, n: 3'd2, src: {2'd0, 2'd2, 2'd0, 2'd0}, ptr_after: 2'd3};
      tbl[1] = '{mask: 4'b1111, n: 3'd4, src: {2'd3, 2'd0, 2'd1, 2'd2}, ptr_after: 2'd3};
      tbl[2] = '{mask: 4'b1010, n: 3'd2, src: {2'd3, 2'd1, 2'd0, 2'd0}, ptr_after: 2'd2};
      tbl[3] = '{mask: 4'b0011, n: 3'd2, src: {2'd0, 2'd1, 2'd0, 2'd0}, ptr_after: 2'd2};
      tbl[4] = '{mask: 4'b1000, n: 3'd1, src: {2'd3, 2'd0, 2'd0, 2'd0}, ptr_after: 2'd0};
      tbl[5] = '{mask: 4'b0110, n: 3'd2, src: {2'd1, 2'd2, 2'd0, 2'd0}, ptr_after: 2'd3};

      bus.fu_valid = '0; bus.fu_tag = '0; bus.fu_data = '0;
      acc = '0;
      model_reset();
      reset = 1'b1;
      @(posedge clk); #1;

      // Reset held two cycles with every FU requesting.
      for (int i = 0; i < N; i++) drive(i, TW'(i + 1), 32'hA000_0000 + 32'(i));
      repeat (2) begin
         cycle();
         chk("reset_no_accept", 64'(dut.full_q), 64'(0));
      end
      reset = 1'b0;
      #2;
      chk("ready_after_reset", 64'(bus.fu_ready), 64'(4'b1111));
      cycle();
      drop_acc();
      chk("no_bcast_after_E0", 64'(bus.cdb_valid), 64'(0));
      cycle();
      chk("first_bcast_valid", 64'(bus.cdb_valid), 64'(1));
      chk("first_bcast_src",   64'(bus.cdb_src),   64'(0));
      repeat (4) cycle();

      // Fairness: all FUs continuously valid.
      clear_obs();
      for (int i = 0; i < N; i++) seq[i] = 0;
      repeat (24) begin
         for (int i = 0; i < N; i++)
            if (!bus.fu_valid[i]) begin
               drive(i, TW'((i << 4) | seq[i]), 32'(i * 1000 + seq[i]));
               seq[i]++;
            end
         cycle();
         drop_acc();
      end
      repeat (8) begin cycle(); drop_acc(); end
      chk("fair_count_ge16", 64'(obs_src.size() >= 16), 64'(1));
      for (int k = 0; k < 16 && k < obs_src.size(); k++) begin
         chk("fair_src",    64'(obs_src[k]), 64'(k % 4));
         chk("fair_tag",    64'(obs_tag[k]), 64'(((k % 4) << 4) | (k / 4)));
         chk("fair_backto", 64'(obs_cyc[k] - obs_cyc[0]), 64'(k));
      end

      // Single FU.
      clear_obs();
      drive(FU_LD, 6'h05, 32'hDEADBEEF);
      cycle(); drop_acc();
      repeat (5) cycle();
      chk("single_count", 64'(obs_src.size()), 64'(1));
      if (obs_src.size() > 0) begin
         chk("single_tag",  64'(obs_tag[0]),  64'(6'h05));
         chk("single_data", 64'(obs_data[0]), 64'(32'hDEADBEEF));
         chk("single_src",  64'(obs_src[0]),  64'(2));
      end

      // Vector table, starting with rr_ptr = 3.
      for (int r = 0; r < 6; r++) begin
         clear_obs();
         for (int i = 0; i < N; i++)
            if (tbl[r].mask[i]) drive(i, TW'(8 * r + i), 32'h1000 * 32'(r) + 32'(i));
         cycle(); drop_acc();
         repeat (6) cycle();
         chk("tbl_count", 64'(obs_src.size()), 64'(tbl[r].n));
         for (int k = 0; k < int'(tbl[r].n) && k < obs_src.size(); k++) begin
            chk("tbl_src", 64'(obs_src[k]), 64'(tbl[r].src[k]));
            chk("tbl_tag", 64'(obs_tag[k]), 64'(8 * r + int'(tbl[r].src[k])));
         end
         chk("tbl_ptr", 64'(dut.rr_ptr_q), 64'(tbl[r].ptr_after));
      end

      // Drain and refill: FU1 streams back-to-back.
      clear_obs();
      seq[1] = 0;
      drive(1, 6'h10, 32'h5500_0000);
      for (int c = 0; c < 14; c++) begin
         cycle();
         if (seq[1] < 8) chk("stream_ready1", 64'(bus.fu_ready[1]), 64'(1));
         if (acc[1]) begin
            seq[1]++;
            if (seq[1] < 8) drive(1, TW'(6'h10 + seq[1]), 32'h5500_0000 + 32'(seq[1]));
            else bus.fu_valid[1] = 1'b0;
         end
      end
      chk("stream_count", 64'(obs_src.size()), 64'(8));
      for (int k = 0; k < 8 && k < obs_src.size(); k++) begin
         chk("stream_tag", 64'(obs_tag[k]), 64'(6'h10 + k));
         chk("stream_gap", 64'(obs_cyc[k] - obs_cyc[0]), 64'(k));
      end

`ifdef CDB_FLUSH_EN
      drive(0, 6'h21, 32'h0BAD_0000);
      drive(3, 6'h24, 32'h0BAD_0003);
      cycle(); drop_acc();
      ptr_save = mptr;
      flush = 1'b1;
      #1;
      chk("flush_ready", 64'(bus.fu_ready), 64'(0));
      cycle();
      flush = 1'b0;
      chk("flush_no_bcast", 64'(bus.cdb_valid), 64'(0));
      chk("flush_empty",    64'(dut.full_q),    64'(0));
      chk("flush_ptr",      64'(dut.rr_ptr_q),  64'(ptr_save));
      clear_obs();
      drive(0, 6'h30, 32'h7777_0000);
      cycle(); drop_acc();
      repeat (3) cycle();
      chk("flush_after_count", 64'(obs_src.size()), 64'(1));
      if (obs_src.size() > 0) chk("flush_after_tag", 64'(obs_tag[0]), 64'(6'h30));
`else
      ptr_save = 0;
`endif

      // Random traffic with occasional reset (and flush when built in).
      for (int c = 0; c < 3000; c++) begin
         drop_acc();
         if ($urandom_range(0, 149) == 0) begin
            reset = 1'b1;
            cycle();
            reset = 1'b0;
            bus.fu_valid = '0;
         end
`ifdef CDB_FLUSH_EN
         else if ($urandom_range(0, 149) == 0) begin
            flush = 1'b1;
            cycle();
            flush = 1'b0;
         end
`endif
         else begin
            for (int i = 0; i < N; i++)
               if (!bus.fu_valid[i] && $urandom_range(0, 99) < 40)
                  drive(i, TW'($urandom), $urandom);
            cycle();
         end
      end
      chk("ptr_save_sane", 64'(ptr_save < N), 64'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
